bsg_xor_keystream_gen: RTL
==========================

// Module: bsg_xor_keystream_gen
// PURPOSE
//  Keystream source feeding the b_i operand of the 128-bit XOR stage (scrambler/whitener datapath).
//  Holds an xorshift128 generator state and presents it as a valid/yumi word stream.
//  Each accepted word advances the generator steps_per_word_p steps. Seeding runs through a dedicated load port.
// PARAMETERS
//  steps_per_word_p  4           xorshift128 steps applied per consumed word (legal 1..4)
//  default_seed_p    128'h075BCD15_159A55E5_1F123BB5_05491333  substitute seed when an all-zero seed is loaded
//  count_width_p     16          width of the consumed-word counter
// PORTS
//  clk_i      in   1              clock
//  reset_i    in   1              reset, asynchronous, active-high
//  seed_v_i   in   1              load seed_i into generator state this cycle
//  seed_i     in   128            seed {x[127:96], y[95:64], z[63:32], w[31:0]}
//  v_o        out  1              data_o holds a valid keystream word
//  data_o     out  128            current keystream word = generator state {x,y,z,w}
//  yumi_i     in   1              consumer takes data_o this cycle (legal only when v_o=1)
//  count_o    out  count_width_p  words consumed since last seed load, wraps modulo 2^count_width_p
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert by system):
//    - state=IDLE, v_o=0, data_o=0, count_o=0.
//    - Takes effect immediately, also mid-stream. Any word in flight is discarded.
//  - FSM states: IDLE, RUN.
//    - IDLE: v_o=0. yumi_i is ignored.
//      - seed_v_i=1 -> state<=seed_i (default_seed_p if seed_i==0), count_o<=0, go to RUN.
//    - RUN: v_o=1, data_o=state register (no combinational path from inputs).
//  - One xorshift128 step on {x,y,z,w}:
//    - t = x ^ (x<<11).
//    - Then {x,y,z,w} <= {y, z, w, w ^ (w>>19) ^ t ^ (t>>8)}.
//    - All 32-bit, shifts logical, overflow bits dropped.
//  - RUN with yumi_i=1 and seed_v_i=0:
//    - State advances steps_per_word_p chained steps in one cycle.
//    - count_o<=count_o+1 (wraps to 0 after all-ones).
//  - RUN with seed_v_i=1 (with or without yumi_i):
//    - Reseed wins; the yumi'd word counts as delivered.
//    - State<=seed (zero-substituted), count_o<=0, stays in RUN.
//  - RUN with neither input: state and count_o hold; data_o stable (consumer may stall indefinitely).
//  - Latency:
//    - Seed load -> v_o=1 with data_o=seed on the next cycle.
//    - yumi -> next word on the next cycle. Full throughput of one word/cycle.
//  - State is never all-zero after a load (zero seed substituted), so the generator never locks up.
//  - yumi_i while v_o=0: illegal; RTL ignores it, bench asserts it never occurs.
// TESTING
//  1. Reset, no seed for 10 cycles, yumi_i toggling -> v_o=0, data_o=0, count_o=0 throughout.
//  2. steps_per_word_p=1; seed default_seed_p -> next cycle data_o=seed.
//     - 1 yumi -> data_o[31:0]=32'hDCA345EA, data_o[127:96]=32'h159A55E5, count_o=1.
//  3. Seed 128'h0 -> data_o=default_seed_p; 1000 back-to-back yumis -> data_o never 0, count_o=1000.
//  4. yumi_i and seed_v_i same cycle, seed=128'h1 -> next data_o=128'h1, count_o=0.
//  5. count_width_p=4; 17 yumis -> count_o wraps 15->0->1.
//     - Stall 5 cycles -> data_o and count_o unchanged.
//  6. Assert reset_i mid-stream between clock edges -> v_o falls without a clock edge.
//     - After release, v_o stays 0 until a new seed is loaded.
//  Plus: cycle-accurate compare against a C xorshift128 model for 10k random seed/yumi/stall sequences.

Source files
------------

// File: rtl/bsg_xor_keystream_gen.sv
// bsg_xor_keystream_gen
// xorshift128 keystream source presented as a valid/yumi word stream.
// Each consumed word advances the generator steps_per_word_p chained steps.
// A dedicated load port seeds the generator. An all-zero seed is replaced by
// default_seed_p so the generator can never lock up at zero.
module bsg_xor_keystream_gen #(
   parameter int             steps_per_word_p = 4,  // legal 1..4
   parameter logic [127:0]   default_seed_p   = 128'h075BCD15_159A55E5_1F123BB5_05491333,
   parameter int             count_width_p    = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     seed_v_i,
   input  logic [127:0]             seed_i,
   output logic                     v_o,
   output logic [127:0]             data_o,
   input  logic                     yumi_i,
   output logic [count_width_p-1:0] count_o
);

   localparam logic [0:0] st_idle = 1'b0;
   localparam logic [0:0] st_run  = 1'b1;

   logic [0:0]               state_q, state_d;
   logic [127:0]             gen_q, gen_d;
   logic [count_width_p-1:0] count_q, count_d;
   logic [127:0]             gen_adv;
   logic [127:0]             seed_sub;

   // One xorshift128 step on {x,y,z,w}; all arithmetic is 32-bit with logical shifts.
   function automatic logic [127:0] xs_step(input logic [127:0] s);
      logic [31:0] x, y, z, w, t, w_new;
      x     = s[127:96];
      y     = s[95:64];
      z     = s[63:32];
      w     = s[31:0];
      t     = x ^ (x << 11);
      w_new = w ^ (w >> 19) ^ t ^ (t >> 8);
      return {y, z, w, w_new};
   endfunction

   // Next generator state after consuming one word: steps_per_word_p chained steps.
   always_comb begin
      gen_adv = gen_q;
      for (int i = 0; i < steps_per_word_p; i++) begin
         gen_adv = xs_step(gen_adv);
      end
   end

   // Zero seed is replaced so the loaded state is never all-zero.
   assign seed_sub = (seed_i == '0) ? default_seed_p : seed_i;

   // Next-state logic: reseed has priority over consumption in both states.
   always_comb begin
      // NOTE: every signal gets a default here so no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      gen_d   = gen_q;
      count_d = count_q;
      unique case (state_q)
         st_idle: begin
            // yumi_i is ignored while no word is valid.
            if (seed_v_i) begin
               gen_d   = seed_sub;
               count_d = '0;
               state_d = st_run;
            end
         end
         st_run: begin
            if (seed_v_i) begin
               gen_d   = seed_sub;
               count_d = '0;
            end else if (yumi_i) begin
               gen_d   = gen_adv;
               count_d = count_q + 1'b1;
            end
         end
         default: begin
            state_d = st_idle;
         end
      endcase
   end

   // State registers with asynchronous reset discarding any word in flight.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
         state_q <= st_idle;
         gen_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         gen_q   <= gen_d;
         count_q <= count_d;
      end
   end

   // Outputs come straight from registers; no combinational path from inputs.
   assign v_o     = (state_q == st_run);
   assign data_o  = gen_q;
   assign count_o = count_q;

endmodule
